// File: rtl/fuzz_vector_sequencer.sv
// Replays stored stimulus vectors into a DUT, captures y per vector
// and folds each capture into a rotating XOR signature.
module fuzz_vector_sequencer #(
  parameter int VEC_W    = 256,
  parameter int Y_W      = 127,
  parameter int SIG_W    = 128,
  parameter int NUM_VEC  = 21,
  parameter int ADDR_W   = 5,
  parameter int HOLD_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              vec_req,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic              vec_valid,
  input  logic [VEC_W-1:0]  vec_data,
  output logic [VEC_W-1:0]  dut_in,
  input  logic [Y_W-1:0]    y_in,
  output logic              cap_valid,
  input  logic              cap_ready,
  output logic [Y_W-1:0]    cap_data,
  output logic [ADDR_W:0]   cap_idx,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  sig
);

  localparam int CNT_W = $clog2(HOLD_CYC + 1) + 1;
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(NUM_VEC);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    CAPTURE,
    FETCH,
    DONE
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      vec_req   <= 1'b0;
      vec_addr  <= '0;
      dut_in    <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sig       <= '0;
    end else if (abort && busy) begin
      // partial signature is kept for post-mortem
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_req   <= 1'b0;
      cap_valid <= 1'b0;
      dut_in    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            sig     <= '0;
            dut_in  <= '0;
            cap_idx <= '0;
            cnt     <= HOLD;
            done    <= 1'b0;
            busy    <= 1'b1;
            state   <= APPLY;
          end
        end
        APPLY: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            cap_data  <= y_in;
            cap_valid <= 1'b1;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_ready) begin
            cap_valid <= 1'b0;
            sig <= {sig[SIG_W-2:0], sig[SIG_W-1]}
                   ^ SIG_W'(cap_data);
            if (cap_idx == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              vec_req  <= 1'b1;
              vec_addr <= cap_idx[ADDR_W-1:0];
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (vec_valid) begin
            dut_in  <= vec_data;
            cap_idx <= cap_idx + 1'b1;
            cnt     <= HOLD;
            vec_req <= 1'b0;
            state   <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Directed bench for fuzz_vector_sequencer with NUM_VEC=2, HOLD_CYC=1:
// table-driven runs plus stall, abort and reset sequences.
module tb_fuzz_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic vec_req, vec_valid, cap_valid, cap_ready, busy, done;
  logic [4:0] vec_addr;
  logic [5:0] cap_idx;
  logic [255:0] vec_data, dut_in;
  logic [126:0] y_in, cap_data;
  logic [127:0] sig;

  int checks = 0;
  int errors = 0;
  int ymode = 0;
  int lat = 1;
  bit extra = 0;
  int wait_cnt = 0;
  logic [255:0] mem [2];

  always #5 clk = ~clk;

  assign y_in = (ymode == 2) ? dut_in[126:0] :
                (ymode == 1) ? 127'd1 : 127'd0;

  fuzz_vector_sequencer #(
    .NUM_VEC(2),
    .HOLD_CYC(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vec_req(vec_req), .vec_addr(vec_addr),
    .vec_valid(vec_valid), .vec_data(vec_data),
    .dut_in(dut_in), .y_in(y_in),
    .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_data(cap_data), .cap_idx(cap_idx),
    .busy(busy), .done(done), .sig(sig)
  );

  // store model: data valid lat negedges after vec_req is seen
  always @(negedge clk) begin
    if (vec_req) begin
      if (wait_cnt >= lat) begin
        vec_valid = 1'b1;
        vec_data = mem[vec_addr[0]];
      end else begin
        vec_valid = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      vec_valid = extra ? ~vec_valid : 1'b0;
      vec_data = '1;
    end
  end

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int what, input string name);
    bit hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      case (what)
        0: hit = cap_valid && cap_idx == 6'd1;
        1: hit = vec_req && vec_addr == 5'd0;
        2: hit = vec_req && vec_addr == 5'd1;
        3: hit = cap_valid;
        default: hit = done;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL timeout_%s got 0 exp 1", name);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_req"}, vec_req, 0);
    chk({name, "_addr"}, vec_addr, 0);
    chk({name, "_cv"}, cap_valid, 0);
    chk({name, "_cd"}, cap_data, 0);
    chk({name, "_ci"}, cap_idx, 0);
    chk({name, "_din"}, dut_in, 0);
    chk({name, "_sig"}, sig, 0);
  endtask

  typedef struct {
    int ymode;
    int lat;
    bit extra;
    logic [2:0][127:0] d;
    logic [2:0][127:0] s;
  } run_t;

  run_t runs [4];

  initial begin
    logic [127:0] da, db, s2;
    int ncap;
    bit pend;
    da = 128'h25A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    db = 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A;
    s2 = 128'h11111111111111111111111111111110;
    mem[0] = {32{8'hA5}};
    mem[1] = {32{8'h5A}};
    runs[0] = '{0, 1, 0, {128'd0, 128'd0, 128'd0},
                {128'd0, 128'd0, 128'd0}};
    runs[1] = '{1, 1, 0, {128'd1, 128'd1, 128'd1},
                {128'd7, 128'd3, 128'd1}};
    runs[2] = '{2, 1, 0, {db, da, 128'd0},
                {s2, da, 128'd0}};
    runs[3] = '{2, 4, 1, {db, da, 128'd0},
                {s2, da, 128'd0}};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cap_ready = 1'b1;
    vec_valid = 1'b0;
    vec_data = '0;
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int r = 0; r < 4; r++) begin
      ymode = runs[r].ymode;
      lat = runs[r].lat;
      extra = runs[r].extra;
      pulse_start();
      chk($sformatf("r%0d_busy", r), busy, 1);
      chk($sformatf("r%0d_done0", r), done, 0);
      ncap = 0;
      pend = 0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (pend) begin
          chk($sformatf("r%0d_sig%0d", r, ncap), sig,
              runs[r].s[ncap]);
          ncap++;
          pend = 0;
        end
        if (done) break;
        if (cap_valid && cap_ready) begin
          if (ncap > 2) begin
            chk($sformatf("r%0d_extra_cap", r), ncap, 2);
            break;
          end
          chk($sformatf("r%0d_idx%0d", r, ncap), cap_idx, ncap);
          chk($sformatf("r%0d_data%0d", r, ncap),
              {1'b0, cap_data}, runs[r].d[ncap]);
          pend = 1;
        end
      end
      chk($sformatf("r%0d_ncap", r), ncap, 3);
      chk($sformatf("r%0d_done", r), done, 1);
      chk($sformatf("r%0d_busy_end", r), busy, 0);
      chk($sformatf("r%0d_final", r), sig, runs[r].s[2]);
    end
    extra = 0;

    // sink stall on capture 1
    ymode = 1;
    lat = 1;
    pulse_start();
    wait_neg(0, "stall");
    cap_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_cv", cap_valid, 1);
      chk("stall_cd", cap_data, 1);
      chk("stall_ci", cap_idx, 1);
      chk("stall_sig", sig, 1);
    end
    cap_ready = 1'b1;
    @(negedge clk);
    chk("stall_sig_after", sig, 3);
    chk("stall_cv_after", cap_valid, 0);
    wait_neg(4, "stall_done");
    chk("stall_final", sig, 7);

    // start mid-run, abort in fetch of vector 1
    lat = 4;
    pulse_start();
    wait_neg(1, "fetch0");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart_sig", sig, 1);
    chk("midstart_busy", busy, 1);
    wait_neg(2, "fetch1");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_req", vec_req, 0);
    chk("abort_cv", cap_valid, 0);
    chk("abort_din", dut_in, 0);
    chk("abort_sig", sig, 3);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", busy, 0);
    chk("abort_wins_sig", sig, 3);

    // async reset during capture
    lat = 1;
    pulse_start();
    wait_neg(3, "cap_rst");
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
